nibble_serial_adder: RTL and testbench

Wide-operand sequencer that sits directly upstream and downstream of the clocked 4-bit CLA stage. It accepts a 4·NIBBLES-bit add request over a valid/ready handshake. It feeds the CLA one nibble per step, LSB nibble first, and chains each returned carry into the next step. It reassembles the sum and presents the full-width result, carry-out and signed overflow over a valid/ready output handshake.

---
 rtl/nibble_serial_adder.sv | 160 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide-operand sequencer around an external clocked 4-bit CLA stage.
// It accepts a W = 4*NIBBLES bit add request over a valid/ready handshake. It then feeds
// the CLA one nibble at a time, LSB first, and chains each returned carry into the next
// nibble. It returns the full-width sum, the carry-out and the signed overflow over a
// valid/ready output handshake.
//
// Ports:
//   CLK, RSTn            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    request handshake; in_a, in_b, in_cin are the operands
//   cla_a/cla_b/cla_cin  registered nibble operands sent to the CLA stage
//   cla_sum/cla_cout     CLA stage results, valid CLA_LAT cycles after an operand change
//   out_valid/out_ready  result handshake; out_sum, out_cout, out_ovf hold the result
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CLA_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_sum,
  input  logic                   cla_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned CntW = $clog2(CLA_LAT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLA_LAT);

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IdxW-1:0] idx_q, idx_d, nxt_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cla_a_q, cla_a_d, cla_b_q, cla_b_d;
  logic            cla_cin_q, cla_cin_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;

  logic [IdxW+1:0] cur_sh, nxt_sh;
  logic [W-1:0]    a_next, b_next, res_cap;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cla_a_d    = cla_a_q;
    cla_b_d    = cla_b_q;
    cla_cin_d  = cla_cin_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    nxt_idx = idx_q + 1'b1;
    cur_sh  = {idx_q, 2'b00};
    nxt_sh  = {nxt_idx, 2'b00};
    a_next  = a_q >> nxt_sh;
    b_next  = b_q >> nxt_sh;
    // Merge the returned nibble into its slot of the partial result.
    res_cap = (res_q & ~(W'(4'hF) << cur_sh)) | (W'(cla_sum) << cur_sh);

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          cla_a_d   = in_a[3:0];
          cla_b_d   = in_b[3:0];
          cla_cin_d = in_cin;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Capture edge: the CLA output now reflects the current nibble.
          res_d = res_cap;
          cnt_d = '0;
          if (idx_q != LastIdx) begin
            idx_d     = nxt_idx;
            cla_a_d   = a_next[3:0];
            cla_b_d   = b_next[3:0];
            cla_cin_d = cla_cout;
          end else begin
            state_d    = StDone;
            out_sum_d  = res_cap;
            out_cout_d = cla_cout;
            out_ovf_d  = (a_q[W-1] == b_q[W-1]) & (res_cap[W-1] != a_q[W-1]);
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      cla_a_q    <= '0;
      cla_b_q    <= '0;
      cla_cin_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cla_a_q    <= cla_a_d;
      cla_b_q    <= cla_b_d;
      cla_cin_q  <= cla_cin_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign cla_a     = cla_a_q;
  assign cla_b     = cla_b_q;
  assign cla_cin   = cla_cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: one instance with CLA_LAT=1 and one with CLA_LAT=2,
// each driving a behavioural CLA stage model. Results are checked against plain-integer
// arithmetic for the sum, the carry and the signed overflow.
module tb_nibble_serial_adder;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        req = 1'b0;
  logic        use2 = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready1, in_ready2, out_valid1, out_valid2;
  logic [3:0]  cla_a1, cla_b1, cla_a2, cla_b2, cla_sum1, cla_sum2;
  logic        cla_cin1, cla_cin2, cla_cout1, cla_cout2;
  logic [15:0] out_sum1, out_sum2;
  logic        out_cout1, out_cout2, out_ovf1, out_ovf2;

  int n_checks = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  nibble_serial_adder #(.NIBBLES(4), .CLA_LAT(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(req & ~use2), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cla_a(cla_a1), .cla_b(cla_b1), .cla_cin(cla_cin1),
    .cla_sum(cla_sum1), .cla_cout(cla_cout1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  nibble_serial_adder #(.NIBBLES(4), .CLA_LAT(2)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(req & use2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cla_a(cla_a2), .cla_b(cla_b2), .cla_cin(cla_cin2),
    .cla_sum(cla_sum2), .cla_cout(cla_cout2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2)
  );

  // CLA stage models: a registered 4-bit adder, one and two cycles deep.
  logic [4:0] c1_s, c2_p, c2_s;
  always @(posedge CLK) begin
    c1_s <= {1'b0, cla_a1} + {1'b0, cla_b1} + {4'b0, cla_cin1};
    c2_p <= {1'b0, cla_a2} + {1'b0, cla_b2} + {4'b0, cla_cin2};
    c2_s <= c2_p;
  end
  assign cla_sum1  = c1_s[3:0];
  assign cla_cout1 = c1_s[4];
  assign cla_sum2  = c2_s[3:0];
  assign cla_cout2 = c2_s[4];

  // Observed view of the instance selected by use2.
  logic        m_in_ready, m_out_valid, m_cla_cin, m_out_cout, m_out_ovf;
  logic [3:0]  m_cla_a, m_cla_b;
  logic [15:0] m_out_sum;
  assign m_in_ready  = use2 ? in_ready2  : in_ready1;
  assign m_out_valid = use2 ? out_valid2 : out_valid1;
  assign m_cla_a     = use2 ? cla_a2     : cla_a1;
  assign m_cla_b     = use2 ? cla_b2     : cla_b1;
  assign m_cla_cin   = use2 ? cla_cin2   : cla_cin1;
  assign m_out_sum   = use2 ? out_sum2   : out_sum1;
  assign m_out_cout  = use2 ? out_cout2  : out_cout1;
  assign m_out_ovf   = use2 ? out_ovf2   : out_ovf1;

  // Carry entering nibble i of a + b + cin.
  function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input int i);
    int unsigned mask, s;
    if (i == 0) return cin;
    mask = (32'd1 << (4 * i)) - 1;
    s = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
    return s[4 * i];
  endfunction

  // One complete transfer with trace, latency, result, backpressure and handshake checks.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic lat2, input int hold, input bit poke);
    int          lpn, exp_lat, lat, s, nib;
    bit          seen;
    logic [16:0] full;
    logic        eovf;
    logic [3:0]  ea, eb;
    lpn     = lat2 ? 3 : 2;
    exp_lat = 4 * lpn;
    full    = {1'b0, a} + {1'b0, b} + 17'(cin);
    s       = int'($signed(a)) + int'($signed(b)) + int'(cin);
    eovf    = (s > 32767) || (s < -32768);
    seen    = 0;
    lat     = 0;

    @(negedge CLK);
    use2 = lat2; in_a = a; in_b = b; in_cin = cin; req = 1'b1;
    out_ready = (hold == 0);
    #1;
    n_checks++;
    if (m_in_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready: got %b want 1", m_in_ready);
    end
    @(posedge CLK);
    #1 req = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);

    for (int k = 0; k < exp_lat + 5; k++) begin
      @(negedge CLK);
      if (m_out_valid) begin
        lat = k; seen = 1; break;
      end
      nib = k / lpn;
      ea = 4'(a >> (4 * nib));
      eb = 4'(b >> (4 * nib));
      n_checks++;
      if (m_cla_a !== ea || m_cla_b !== eb || m_cla_cin !== carry_into(a, b, cin, nib)) begin
        n_err++;
        $display("FAIL cla_trace cyc=%0d: got a=%h b=%h c=%b want a=%h b=%h c=%b", k, m_cla_a,
                 m_cla_b, m_cla_cin, ea, eb, carry_into(a, b, cin, nib));
      end
      n_checks++;
      if (m_in_ready !== 1'b0) begin
        n_err++; $display("FAIL busy_ready cyc=%0d: got %b want 0", k, m_in_ready);
      end
    end

    n_checks++;
    if (!seen) begin
      n_err++; $display("FAIL out_valid_timeout: got none want at %0d", exp_lat);
      return;
    end
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL latency: got %0d want %0d", lat, exp_lat);
    end
    n_checks++;
    if (m_out_sum !== full[15:0] || m_out_cout !== full[16] || m_out_ovf !== eovf) begin
      n_err++;
      $display("FAIL result %h+%h+%b: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               a, b, cin, m_out_sum, m_out_cout, m_out_ovf, full[15:0], full[16], eovf);
    end

    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge CLK);
      n_checks++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_out_sum !== full[15:0]) begin
        n_err++;
        $display("FAIL backpressure h=%0d: got v=%b r=%b sum=%h want v=1 r=0 sum=%h", h,
                 m_out_valid, m_in_ready, m_out_sum, full[15:0]);
      end
      req = poke && (h == 1);
    end
    // Handshake edge; with poke the request is presented on that same edge.
    out_ready = 1'b1;
    req = poke;
    @(negedge CLK);
    n_checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_out_sum !== full[15:0]) begin
      n_err++;
      $display("FAIL post_handshake: got v=%b r=%b sum=%h want v=0 r=1 sum=%h", m_out_valid,
               m_in_ready, m_out_sum, full[15:0]);
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    #2 RSTn = 1'b0;
    #3;
    n_checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || cla_a1 !== 4'h0 || cla_b1 !== 4'h0 ||
        cla_cin1 !== 1'b0 || out_sum1 !== 16'h0 || out_cout1 !== 1'b0 || out_ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got r=%b v=%b a=%h b=%h c=%b sum=%h co=%b ov=%b want 1 0 0..",
               in_ready1, out_valid1, cla_a1, cla_b1, cla_cin1, out_sum1, out_cout1, out_ovf1);
    end
    n_checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      n_err++; $display("FAIL reset_state2: got r=%b v=%b want r=1 v=0", in_ready2, out_valid2);
    end
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_directed;
    run_op(16'h0003, 16'h0002, 1'b1, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_backpressure;
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 5, 1);
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    use2 = 1'b0; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; req = 1'b1;
    @(posedge CLK);
    #1 req = 1'b0;
    repeat (5) @(negedge CLK);  // now inside nibble 2
    #2 RSTn = 1'b0;
    #1;
    n_checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || cla_a1 !== 4'h0 || cla_b1 !== 4'h0 ||
        cla_cin1 !== 1'b0 || out_sum1 !== 16'h0 || out_cout1 !== 1'b0 || out_ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got r=%b v=%b a=%h b=%h c=%b sum=%h co=%b ov=%b want 1 0 0..",
               in_ready1, out_valid1, cla_a1, cla_b1, cla_cin1, out_sum1, out_cout1, out_ovf1);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    run_op(16'h000F, 16'h0001, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_lat2;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, 0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, 2, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_lat2();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
